// File: rtl/divisor_datapath.sv
// divisor_datapath: restoring shift-subtract divider datapath sequenced by a one-hot state vector; define ONEHOT_CHECK_EN for a sticky illegal-state flag
module divisor_datapath #(
  parameter int WIDTH = 16,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic [7:0]       Est,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             divisorNoCero,
  output logic             Cont16NoCero,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo,
  output logic             listo,
  output logic             errorDiv,
  output logic             estIlegal
);
  logic [WIDTH-1:0] d_q, r_q, q_q;
  logic [WIDTH:0]   diff_q;
  logic [CW-1:0]    cnt_q;
  logic             est_ok;
  assign est_ok        = (Est != 8'd0) && ((Est & (Est - 8'd1)) == 8'd0);
  assign divisorNoCero = |d_q;
  assign Cont16NoCero  = |cnt_q;
  // datapath and result registers, each state bit owning its own update; anything not exactly one-hot holds
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      d_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      cociente <= '0;
      residuo  <= '0;
      listo    <= 1'b0;
      errorDiv <= 1'b0;
    end else if (est_ok) begin
      if (Est[0]) begin
        d_q      <= divisor;
        q_q      <= dividendo;
        listo    <= 1'b0;
        errorDiv <= 1'b0;
      end
      if (Est[1] && d_q == '0) begin
        cociente <= '1;
        residuo  <= q_q;
        errorDiv <= 1'b1;
        listo    <= 1'b1;
      end
      if (Est[2]) begin
        r_q   <= '0;
        cnt_q <= CW'(WIDTH);
      end
      if (Est[3]) {r_q, q_q} <= {r_q[WIDTH-2:0], q_q, 1'b0};
      if (Est[4]) begin
        diff_q <= {1'b0, r_q} - {1'b0, d_q};
        cnt_q  <= cnt_q - CW'(1);
      end
      if (Est[5] && !diff_q[WIDTH]) begin
        r_q    <= diff_q[WIDTH-1:0];
        q_q[0] <= 1'b1;
      end
      if (Est[6]) begin
        cociente <= q_q;
        residuo  <= r_q;
        listo    <= 1'b1;
        errorDiv <= 1'b0;
      end
    end
  end
`ifdef ONEHOT_CHECK_EN
  // sticky record of any edge that saw a malformed state vector
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) estIlegal <= 1'b0;
    else if (!est_ok) estIlegal <= 1'b1;
  end
`else
  assign estIlegal = 1'b0;
`endif
endmodule

// File: tb/tb_divisor_datapath.sv
// tb_divisor_datapath: randomized divides against an arithmetic reference, plus directed corner cases
module tb_divisor_datapath;
  localparam int W = 16;
`ifdef ONEHOT_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif
  logic reloj = 1'b0, reset = 1'b0;
  logic [7:0] Est = 8'h01;
  logic [W-1:0] dividendo = '0, divisor = '0;
  logic divisorNoCero, Cont16NoCero, listo, errorDiv, estIlegal;
  logic [W-1:0] cociente, residuo;
  int checks = 0, failures = 0;
  bit chk_en = 1'b0;
  logic [W-1:0] a_m, b_m, e_coc, e_res;
  bit e_listo, e_err, e_ill;
  int cnt_m;
  divisor_datapath #(.WIDTH(W)) dut (
    .reloj(reloj), .reset(reset), .Est(Est), .dividendo(dividendo), .divisor(divisor),
    .divisorNoCero(divisorNoCero), .Cont16NoCero(Cont16NoCero), .cociente(cociente),
    .residuo(residuo), .listo(listo), .errorDiv(errorDiv), .estIlegal(estIlegal)
  );
  always #5 reloj = ~reloj;
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge reloj) if (chk_en) begin
    chk("cociente", cociente, e_coc);
    chk("residuo", residuo, e_res);
    chk("listo", listo, e_listo);
    chk("errorDiv", errorDiv, e_err);
    chk("divisorNoCero", divisorNoCero, b_m != 0);
    chk("Cont16NoCero", Cont16NoCero, cnt_m != 0);
    chk("estIlegal", estIlegal, e_ill);
  end
  task automatic model_reset();
    a_m = '0; b_m = '0; e_coc = '0; e_res = '0;
    e_listo = 0; e_err = 0; e_ill = 0; cnt_m = 0;
  endtask
  task automatic tick(input logic [7:0] e);
    Est = e;
    @(posedge reloj);
    #1;
    if ($countones(e) != 1) e_ill = e_ill | ILL_EN;
    else if (e == 8'h01) begin a_m = dividendo; b_m = divisor; e_listo = 0; e_err = 0; end
    else if (e == 8'h02 && b_m == 0) begin e_coc = '1; e_res = a_m; e_err = 1; e_listo = 1; end
    else if (e == 8'h04) cnt_m = W;
    else if (e == 8'h10) cnt_m = cnt_m - 1;
    else if (e == 8'h40) begin e_coc = a_m / b_m; e_res = a_m % b_m; e_listo = 1; e_err = 0; end
  endtask
  task automatic tick_illegal();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    while ($countones(v) == 1) v = 8'($urandom_range(0, 255));
    tick(v);
  endtask
  task automatic maybe_illegal();
    if ($urandom_range(0, 9) == 0) tick_illegal();
  endtask
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int rst_at, input int ill_at,
                     output bit aborted);
    aborted = 0;
    dividendo = a; divisor = b;
    tick(8'h01);
    maybe_illegal();
    dividendo = W'($urandom); divisor = W'($urandom);
    tick(8'h02);
    if (b == 0) return;
    maybe_illegal();
    tick(8'h04);
    for (int i = 1; i <= W; i++) begin
      tick(8'h08);
      if (i == rst_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_cociente", cociente, 0);
        chk("rst_residuo", residuo, 0);
        chk("rst_listo", listo, 0);
        chk("rst_errorDiv", errorDiv, 0);
        chk("rst_divisorNoCero", divisorNoCero, 0);
        chk("rst_Cont16NoCero", Cont16NoCero, 0);
        model_reset();
        @(negedge reloj);
        #1 reset = 1'b0;
        aborted = 1;
        return;
      end
      if (i == ill_at) begin
        tick(8'b0001_1000);
        chk("estIlegal_set", estIlegal, ILL_EN);
      end else maybe_illegal();
      tick(8'h10);
      maybe_illegal();
      tick(8'h20);
    end
    tick(8'h40);
  endtask
  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bit ab;
    logic [W-1:0] a, b;
    #1 reset = 1'b1;
    model_reset();
    chk_en = 1'b1;
    #1;
    chk("reset_cociente", cociente, 0);
    chk("reset_listo", listo, 0);
    repeat (2) @(negedge reloj);
    #1 reset = 1'b0;
    run(100, 7, -1, 5, ab);
    chk("q_100_7", cociente, 14);
    chk("r_100_7", residuo, 2);
    chk("listo_100_7", listo, 1);
    chk("err_100_7", errorDiv, 0);
    chk("estIlegal_sticky", estIlegal, ILL_EN);
    tick(8'h80); tick(8'h80);
    run(16'hFFFF, 1, -1, -1, ab);
    chk("q_ffff_1", cociente, 16'hFFFF);
    chk("r_ffff_1", residuo, 0);
    tick(8'h80);
    run(3, 10, -1, -1, ab);
    chk("q_3_10", cociente, 0);
    chk("r_3_10", residuo, 3);
    tick(8'h80);
    run(5, 0, -1, -1, ab);
    chk("q_5_0", cociente, 16'hFFFF);
    chk("r_5_0", residuo, 5);
    chk("err_5_0", errorDiv, 1);
    chk("listo_5_0", listo, 1);
    chk("dnz_5_0", divisorNoCero, 0);
    tick(8'h80);
    run(100, 7, 8, -1, ab);
    run(100, 7, -1, -1, ab);
    chk("q_after_reset", cociente, 14);
    chk("r_after_reset", residuo, 2);
    tick(8'h80);
    for (int k = 0; k < 40; k++) begin
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1, 2: b = W'($urandom_range(1, 15));
        3: b = a;
        default: b = W'($urandom);
      endcase
      run(a, b, -1, -1, ab);
      repeat ($urandom_range(1, 3)) tick(8'h80);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
